// File: rtl/nf10_upb_defs.sv
// -----------------------------------------------------------------------------
// nf10_upb_defs
// Definitions shared by the UPB egress demux and the UPB input arbiter:
//   - demux FSM state encodings (HEAD / BODY / DROP)
//   - default widths of the tuser sideband fields
// No ports; import with "import nf10_upb_defs::*;".
// -----------------------------------------------------------------------------
package nf10_upb_defs;

   // Default tuser sideband widths, kept identical on both sides of the switch
   localparam int C_DEF_PACKET_LENGTH_WIDTH = 14;
   localparam int C_DEF_IN_PORT_WIDTH       = 3;
   localparam int C_DEF_OUT_PORT_WIDTH      = 8;

   // HEAD: the next accepted beat starts a packet
   // BODY: forwarding the rest of a packet to the latched destination set
   // DROP: swallowing the rest of a packet that has no destination
   typedef enum logic [1:0] {
      HEAD = 2'd0,
      BODY = 2'd1,
      DROP = 2'd2
   } demuxState_e;

endpackage

// File: rtl/nf10_upb_axis_slice.sv
// -----------------------------------------------------------------------------
// nf10_upb_axis_slice
// One-beat AXI4-Stream register slice. The owner decides when to load (it
// checks free_o for every destination first); the slice holds the beat until
// the downstream ready handshakes it.
// Ports:
//   clk, resetn   clock, asynchronous active-low clear (valid and payload)
//   load_i        capture payload_i this cycle
//   payload_i     beat to capture (opaque bundle of data and sideband)
//   ready_i       downstream tready
//   valid_o       downstream tvalid
//   payload_o     registered beat
//   free_o        slot can take a beat this cycle (empty or draining)
// -----------------------------------------------------------------------------
module nf10_upb_axis_slice #(
   parameter int C_WIDTH = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load_i,
   input  logic [C_WIDTH-1:0] payload_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [C_WIDTH-1:0] payload_o,
   output logic               free_o
);

   logic               valid_q;
   logic               valid_d;
   logic [C_WIDTH-1:0] payload_q;

   assign free_o    = ~valid_q | ready_i;
   assign valid_o   = valid_q;
   assign payload_o = payload_q;

   // A load wins over a handshake, so a beat arriving while the old one
   // drains keeps the slot valid with no bubble.
   always_comb begin
      valid_d = valid_q;
      if (load_i) begin
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Payload only moves on a load, so it is stable while valid & !ready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q <= valid_d;
         if (load_i) begin
            payload_q <= payload_i;
         end
      end
   end

endmodule

// File: rtl/nf10_upb_output_demux_flex.sv
// -----------------------------------------------------------------------------
// nf10_upb_output_demux_flex
// Egress demux: fans one AXI4-Stream packet stream out to C_NUM_OUTPUTS
// streams. The head beat's tuser_out_port bitmask selects the destinations;
// multicast copies advance in lockstep. Packets with no destination among the
// implemented outputs are swallowed and counted in drop_count.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   s_axis_*               slave stream plus five tuser sideband fields
//   m_axis_*               flattened master streams, output i in slice i
//   m_axis_tready          per-output ready
//   drop_count             discarded packets, wraps
// -----------------------------------------------------------------------------
module nf10_upb_output_demux_flex
   import nf10_upb_defs::*;
#(
   parameter int C_DATA_WIDTH          = 256,
   parameter int C_TKEEP_WIDTH         = C_DATA_WIDTH / 8,
   parameter int C_PACKET_LENGTH_WIDTH = C_DEF_PACKET_LENGTH_WIDTH,
   parameter int C_IN_PORT_WIDTH       = C_DEF_IN_PORT_WIDTH,
   parameter int C_OUT_PORT_WIDTH      = C_DEF_OUT_PORT_WIDTH,
   parameter int C_NUM_OUTPUTS         = 5,
   parameter int C_DROP_CNT_WIDTH      = 16
) (
   input  logic                                          clk,
   input  logic                                          resetn,

   input  logic [C_DATA_WIDTH-1:0]                       s_axis_tdata,
   input  logic [C_TKEEP_WIDTH-1:0]                      s_axis_tkeep,
   input  logic                                          s_axis_tlast,
   input  logic                                          s_axis_tvalid,
   input  logic [C_PACKET_LENGTH_WIDTH-1:0]              s_axis_tuser_packet_length,
   input  logic [C_IN_PORT_WIDTH-1:0]                    s_axis_tuser_in_port,
   input  logic [C_OUT_PORT_WIDTH-1:0]                   s_axis_tuser_out_port,
   input  logic [C_IN_PORT_WIDTH-1:0]                    s_axis_tuser_in_vport,
   input  logic [C_OUT_PORT_WIDTH-1:0]                   s_axis_tuser_out_vport,
   output logic                                          s_axis_tready,

   output logic [C_NUM_OUTPUTS*C_DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [C_NUM_OUTPUTS*C_TKEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic [C_NUM_OUTPUTS-1:0]                       m_axis_tlast,
   output logic [C_NUM_OUTPUTS-1:0]                       m_axis_tvalid,
   output logic [C_NUM_OUTPUTS*C_PACKET_LENGTH_WIDTH-1:0] m_axis_tuser_packet_length,
   output logic [C_NUM_OUTPUTS*C_IN_PORT_WIDTH-1:0]       m_axis_tuser_in_port,
   output logic [C_NUM_OUTPUTS*C_OUT_PORT_WIDTH-1:0]      m_axis_tuser_out_port,
   output logic [C_NUM_OUTPUTS*C_IN_PORT_WIDTH-1:0]       m_axis_tuser_in_vport,
   output logic [C_NUM_OUTPUTS*C_OUT_PORT_WIDTH-1:0]      m_axis_tuser_out_vport,
   input  logic [C_NUM_OUTPUTS-1:0]                       m_axis_tready,

   output logic [C_DROP_CNT_WIDTH-1:0]                    drop_count
);

   localparam int PW = C_DATA_WIDTH + C_TKEEP_WIDTH + 1 + C_PACKET_LENGTH_WIDTH
                     + 2 * C_IN_PORT_WIDTH + 2 * C_OUT_PORT_WIDTH;

   demuxState_e                 state_q, state_d;
   logic [C_NUM_OUTPUTS-1:0]    mask_q, mask_d;
   logic [C_DROP_CNT_WIDTH-1:0] dropCnt_q;

   logic [C_NUM_OUTPUTS-1:0]    effMask;
   logic [C_NUM_OUTPUTS-1:0]    slotFree;
   logic [C_NUM_OUTPUTS-1:0]    slotLoad;
   logic                        accept;
   logic                        dropInc;
   logic [PW-1:0]               inPayload;
   logic [PW-1:0]               slotPayload [C_NUM_OUTPUTS];

   // Upper out_port bits name outputs that do not exist here and are ignored.
   assign effMask = (state_q == HEAD) ? s_axis_tuser_out_port[C_NUM_OUTPUTS-1:0] : mask_q;

   assign inPayload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                       s_axis_tuser_packet_length, s_axis_tuser_in_port,
                       s_axis_tuser_out_port, s_axis_tuser_in_vport,
                       s_axis_tuser_out_vport};

   assign drop_count = dropCnt_q;

   // State and mask registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= HEAD;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   // Next state. A head beat that is also the last beat leaves us in HEAD.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      unique case (state_q)
         HEAD: begin
            if (accept && !s_axis_tlast) begin
               state_d = (effMask != '0) ? BODY : DROP;
               mask_d  = effMask;
            end
         end
         BODY, DROP: begin
            if (accept && s_axis_tlast) begin
               state_d = HEAD;
            end
         end
         default: state_d = HEAD;
      endcase
   end

   // Outputs of the FSM. Ready needs every destination slot free so the copies
   // stay in lockstep; with no destination the beat is simply swallowed.
   // Ready is gated by resetn so nothing is accepted while held in reset.
   always_comb begin
      s_axis_tready = resetn & ((state_q == DROP) || (effMask == '0) ||
                                (&(slotFree | ~effMask)));
      accept        = s_axis_tvalid & s_axis_tready;
      slotLoad      = accept ? effMask : '0;
      dropInc       = accept & s_axis_tlast &
                      ((state_q == DROP) || ((state_q == HEAD) && (effMask == '0)));
   end

   // Drop counter, wraps naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dropCnt_q <= '0;
      end else if (dropInc) begin
         dropCnt_q <= dropCnt_q + 1'b1;
      end
   end

   for (genvar i = 0; i < C_NUM_OUTPUTS; i++) begin : gSlot
      nf10_upb_axis_slice #(
         .C_WIDTH (PW)
      ) uSlice (
         .clk       (clk),
         .resetn    (resetn),
         .load_i    (slotLoad[i]),
         .payload_i (inPayload),
         .ready_i   (m_axis_tready[i]),
         .valid_o   (m_axis_tvalid[i]),
         .payload_o (slotPayload[i]),
         .free_o    (slotFree[i])
      );

      assign {m_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH],
              m_axis_tkeep[i*C_TKEEP_WIDTH +: C_TKEEP_WIDTH],
              m_axis_tlast[i],
              m_axis_tuser_packet_length[i*C_PACKET_LENGTH_WIDTH +: C_PACKET_LENGTH_WIDTH],
              m_axis_tuser_in_port[i*C_IN_PORT_WIDTH +: C_IN_PORT_WIDTH],
              m_axis_tuser_out_port[i*C_OUT_PORT_WIDTH +: C_OUT_PORT_WIDTH],
              m_axis_tuser_in_vport[i*C_IN_PORT_WIDTH +: C_IN_PORT_WIDTH],
              m_axis_tuser_out_vport[i*C_OUT_PORT_WIDTH +: C_OUT_PORT_WIDTH]} = slotPayload[i];
   end

endmodule
